// File: rtl/distance_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : distance_pair_scheduler
// Description : Walks every index pair (i<j) of a loaded weight-index list
//               through an external combinational distance calculator and
//               streams valid (i, j, dr) results on a valid/ready interface.
//               Optional macro DIST_SCHED_STATS_EN adds emit/skip counters.
// Revision    : 1.0 - initial release
// ============================================================================
module distance_pair_scheduler #(
    parameter int WORD_WIDTH = 8,
    parameter int DIST_WIDTH = 7,
    parameter int IDX_DEPTH  = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] cfg_ow,
    input  logic [WORD_WIDTH-1:0] cfg_fw,
    input  logic [WORD_WIDTH-1:0] cfg_st,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] calc_idx1,
    output logic [WORD_WIDTH-1:0] calc_idx2,
    output logic [WORD_WIDTH-1:0] calc_ow,
    output logic [WORD_WIDTH-1:0] calc_fw,
    output logic [WORD_WIDTH-1:0] calc_st,
    input  logic                  calc_valid,
    input  logic [DIST_WIDTH-1:0] calc_dr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  out_i,
    output logic [CNT_WIDTH-1:0]  out_j,
    output logic [DIST_WIDTH-1:0] out_dr
`ifdef DIST_SCHED_STATS_EN
    ,
    output logic [2*CNT_WIDTH-1:0] stat_emit,
    output logic [2*CNT_WIDTH-1:0] stat_skip
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH:0]   CNT_ONE  = (CNT_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH:0]   CNT_TWO  = (CNT_WIDTH+1)'(2);
    localparam logic [CNT_WIDTH:0]   CNT_FULL = (CNT_WIDTH+1)'(IDX_DEPTH);
    localparam logic [CNT_WIDTH-1:0] PTR_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] PTR_TWO  = CNT_WIDTH'(2);

    state_t                state_q, state_d;
    logic [CNT_WIDTH:0]    count_q, count_d;
    logic [CNT_WIDTH-1:0]  i_q, i_d, j_q, j_d;
    logic [WORD_WIDTH-1:0] ow_q, ow_d, fw_q, fw_d, st_q, st_d;
    logic [WORD_WIDTH-1:0] list_q [IDX_DEPTH];
    logic                  ov_q, ov_d;
    logic [CNT_WIDTH-1:0]  oi_q, oi_d, oj_q, oj_d;
    logic [DIST_WIDTH-1:0] odr_q, odr_d;

    logic list_we;
    logic slot_free;
    logic load_beat;
    logic row_end;
    logic last_pair;

    assign full      = (count_q == CNT_FULL);
    assign list_we   = (state_q == ST_IDLE) && wr_en && !full;
    assign slot_free = !ov_q || out_ready;
    assign load_beat = (state_q == ST_RUN) && calc_valid && slot_free;
    assign row_end   = ({1'b0, j_q} == (count_q - CNT_ONE));
    assign last_pair = row_end && ({1'b0, i_q} == (count_q - CNT_TWO));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        i_d     = i_q;
        j_d     = j_q;
        ow_d    = ow_q;
        fw_d    = fw_q;
        st_d    = st_q;
        ov_d    = ov_q;
        oi_d    = oi_q;
        oj_d    = oj_q;
        odr_d   = odr_q;

        // The write lands before start looks at count, so start sees count+1.
        if (list_we) begin
            count_d = count_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ow_d    = cfg_ow;
                    fw_d    = cfg_fw;
                    st_d    = cfg_st;
                    i_d     = '0;
                    j_d     = PTR_ONE;
                    state_d = (count_d >= CNT_TWO) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (load_beat) begin
                    ov_d  = 1'b1;
                    oi_d  = i_q;
                    oj_d  = j_q;
                    odr_d = calc_dr;
                end else if (out_ready) begin
                    ov_d = 1'b0;
                end
                // Invalid pairs never need the output slot, so they advance even when stalled.
                if (!calc_valid || slot_free) begin
                    if (last_pair) begin
                        state_d = ST_DRAIN;
                    end else if (row_end) begin
                        i_d = i_q + PTR_ONE;
                        j_d = i_q + PTR_TWO;
                    end else begin
                        j_d = j_q + PTR_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    ov_d = 1'b0;
                end
                if (slot_free) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ow_q    <= '0;
            fw_q    <= '0;
            st_q    <= '0;
            ov_q    <= 1'b0;
            oi_q    <= '0;
            oj_q    <= '0;
            odr_q   <= '0;
            for (int k = 0; k < IDX_DEPTH; k++) begin
                list_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            i_q     <= i_d;
            j_q     <= j_d;
            ow_q    <= ow_d;
            fw_q    <= fw_d;
            st_q    <= st_d;
            ov_q    <= ov_d;
            oi_q    <= oi_d;
            oj_q    <= oj_d;
            odr_q   <= odr_d;
            if (list_we) begin
                list_q[count_q[CNT_WIDTH-1:0]] <= wr_data;
            end
        end
    end

`ifdef DIST_SCHED_STATS_EN
    logic [2*CNT_WIDTH-1:0] emit_q, skip_q;
    logic                   start_acc;
    logic                   skip_evt;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign skip_evt  = (state_q == ST_RUN) && !calc_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            emit_q <= '0;
            skip_q <= '0;
        end else if (start_acc) begin
            emit_q <= '0;
            skip_q <= '0;
        end else begin
            if (load_beat) begin
                emit_q <= emit_q + (2*CNT_WIDTH)'(1);
            end
            if (skip_evt) begin
                skip_q <= skip_q + (2*CNT_WIDTH)'(1);
            end
        end
    end

    assign stat_emit = emit_q;
    assign stat_skip = skip_q;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign calc_idx1 = list_q[i_q];
    assign calc_idx2 = list_q[j_q];
    assign calc_ow   = ow_q;
    assign calc_fw   = fw_q;
    assign calc_st   = st_q;
    assign out_valid = ov_q;
    assign out_i     = oi_q;
    assign out_j     = oj_q;
    assign out_dr    = odr_q;

endmodule
`default_nettype wire
